dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single data memory port.
// Each granted transaction runs IDLE -> ISSUE -> BUSY -> RESP, with a stall timeout in BUSY.
module dmem_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [11:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic [3:0]  a_sign_mask,
    output logic        a_done,
    output logic        a_err,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [11:0] b_addr,
    input  logic [31:0] b_wdata,
    input  logic [3:0]  b_sign_mask,
    output logic        b_done,
    output logic        b_err,
    output logic [31:0] b_rdata,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_sign_mask,
    output logic        mem_memread,
    output logic        mem_memwrite,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall,
    output logic        timeout_flag
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY,
        RESP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              lastB_q;
    logic              portB_q;
    logic              we_q;
    logic [11:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        mask_q;
    logic              memRead_q;
    logic              memWrite_q;
    logic              aDone_q;
    logic              bDone_q;
    logic              aErr_q;
    logic              bErr_q;
    logic [31:0]       aRdata_q;
    logic [31:0]       bRdata_q;
    logic              timeout_q;

    logic              grantB_d;
    logic              grantWe_d;
    logic [11:0]       grantAddr_d;
    logic [31:0]       grantWdata_d;
    logic [3:0]        grantMask_d;

    // On a tie, the port that did not win last time gets the grant.
    assign grantB_d     = b_req && (!a_req || !lastB_q);
    assign grantWe_d    = grantB_d ? b_we        : a_we;
    assign grantAddr_d  = grantB_d ? b_addr      : a_addr;
    assign grantWdata_d = grantB_d ? b_wdata     : a_wdata;
    assign grantMask_d  = grantB_d ? b_sign_mask : a_sign_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lastB_q    <= 1'b1;
            portB_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mask_q     <= '0;
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            aDone_q    <= 1'b0;
            bDone_q    <= 1'b0;
            aErr_q     <= 1'b0;
            bErr_q     <= 1'b0;
            aRdata_q   <= '0;
            bRdata_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            aDone_q    <= 1'b0;
            bDone_q    <= 1'b0;
            aErr_q     <= 1'b0;
            bErr_q     <= 1'b0;
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!mem_clk_stall && (a_req || b_req)) begin
                        portB_q    <= grantB_d;
                        lastB_q    <= grantB_d;
                        we_q       <= grantWe_d;
                        addr_q     <= grantAddr_d;
                        wdata_q    <= grantWdata_d;
                        mask_q     <= grantMask_d;
                        memRead_q  <= !grantWe_d;
                        memWrite_q <= grantWe_d;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= BUSY;
                end
                BUSY: begin
                    // Completion and timeout both report through RESP; stall tells them apart.
                    if (!mem_clk_stall || cnt_q == CNT_LAST) begin
                        state_q <= RESP;
                        aDone_q <= !portB_q;
                        bDone_q <= portB_q;
                        aErr_q  <= !portB_q && mem_clk_stall;
                        bErr_q  <= portB_q && mem_clk_stall;
                        if (mem_clk_stall) begin
                            timeout_q <= 1'b1;
                        end else if (!we_q) begin
                            if (portB_q) begin
                                bRdata_q <= mem_read_data;
                            end else begin
                                aRdata_q <= mem_read_data;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign a_done         = aDone_q;
    assign a_err          = aErr_q;
    assign a_rdata        = aRdata_q;
    assign b_done         = bDone_q;
    assign b_err          = bErr_q;
    assign b_rdata        = bRdata_q;
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_sign_mask  = mask_q;
    assign mem_memread    = memRead_q;
    assign mem_memwrite   = memWrite_q;
    assign timeout_flag   = timeout_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-timing model.
module tb_dmem_arbiter;

    localparam int TO = 16;

    logic        clk;
    logic        reset;
    logic        aReq, aWe, bReq, bWe;
    logic [11:0] aAddr, bAddr;
    logic [31:0] aWdata, bWdata;
    logic [3:0]  aMask, bMask;
    logic        aDone, aErr, bDone, bErr;
    logic [31:0] aRdata, bRdata;
    logic [11:0] memAddr;
    logic [31:0] memWriteData;
    logic [3:0]  memSignMask;
    logic        memMemread, memMemwrite;
    logic [31:0] memReadData;
    logic        memClkStall;
    logic        timeoutFlag;

    int checkCount = 0;
    int errorCount = 0;

    dmem_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk(clk), .reset(reset),
        .a_req(aReq), .a_we(aWe), .a_addr(aAddr), .a_wdata(aWdata), .a_sign_mask(aMask),
        .a_done(aDone), .a_err(aErr), .a_rdata(aRdata),
        .b_req(bReq), .b_we(bWe), .b_addr(bAddr), .b_wdata(bWdata), .b_sign_mask(bMask),
        .b_done(bDone), .b_err(bErr), .b_rdata(bRdata),
        .mem_addr(memAddr), .mem_write_data(memWriteData), .mem_sign_mask(memSignMask),
        .mem_memread(memMemread), .mem_memwrite(memMemwrite),
        .mem_read_data(memReadData), .mem_clk_stall(memClkStall),
        .timeout_flag(timeoutFlag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ar, input logic aw, input logic [11:0] aa,
                                 input logic br, input logic bw, input logic [11:0] ba,
                                 input logic [31:0] bwd, input logic [3:0] bm,
                                 input logic st, input logic [31:0] rd);
        aReq = ar; aWe = aw; aAddr = aa; aWdata = 32'h0; aMask = 4'hF;
        bReq = br; bWe = bw; bAddr = ba; bWdata = bwd; bMask = bm;
        memClkStall = st; memReadData = rd;
    endtask

    // The model tracks a transaction by the cycle it was granted and the cycle its done pulses.
    int          cyc = 0;
    int          gCyc = -1;
    int          doneCyc = -1;
    bit          mLastB = 1'b1;
    bit          mPortB = 1'b0;
    bit          mWe = 1'b0;
    bit          mErr = 1'b0;
    bit          mTimeout = 1'b0;
    logic [11:0] mAddr = '0;
    logic [31:0] mWdata = '0;
    logic [3:0]  mMask = '0;
    logic [31:0] mRdata [2];
    bit          eRead, eWrite, eADone, eBDone, eAErr, eBErr;

    initial begin : refModel
        int t;
        int n;
        mRdata[0] = '0;
        mRdata[1] = '0;
        forever begin
            @(posedge clk);
            t = cyc;
            cyc++;
            n = cyc;
            if (reset) begin
                gCyc = -1; doneCyc = -1; mLastB = 1'b1; mPortB = 1'b0; mWe = 1'b0; mErr = 1'b0;
                mAddr = '0; mWdata = '0; mMask = '0; mRdata[0] = '0; mRdata[1] = '0; mTimeout = 1'b0;
            end else begin
                if (doneCyc >= 0 && t > doneCyc) begin
                    gCyc = -1;
                    doneCyc = -1;
                end
                if (gCyc < 0) begin
                    if (!memClkStall && (aReq || bReq)) begin
                        mPortB = bReq && (!aReq || !mLastB);
                        mLastB = mPortB;
                        gCyc = t;
                        mWe = mPortB ? bWe : aWe;
                        mAddr = mPortB ? bAddr : aAddr;
                        mWdata = mPortB ? bWdata : aWdata;
                        mMask = mPortB ? bMask : aMask;
                    end
                end else if (doneCyc < 0 && t >= gCyc + 2) begin
                    if (!memClkStall) begin
                        doneCyc = t + 1;
                        mErr = 1'b0;
                        if (!mWe) mRdata[mPortB] = memReadData;
                    end else if (t - (gCyc + 2) == TO - 1) begin
                        doneCyc = t + 1;
                        mErr = 1'b1;
                        mTimeout = 1'b1;
                    end
                end
            end
            eRead  = (gCyc >= 0) && (n == gCyc + 1) && !mWe;
            eWrite = (gCyc >= 0) && (n == gCyc + 1) && mWe;
            eADone = (doneCyc == n) && !mPortB;
            eBDone = (doneCyc == n) && mPortB;
            eAErr  = eADone && mErr;
            eBErr  = eBDone && mErr;
            #1;
            checkOutput("strobes", 64'({memMemread, memMemwrite}), 64'({eRead, eWrite}));
            checkOutput("doneErr", 64'({aDone, aErr, bDone, bErr}), 64'({eADone, eAErr, eBDone, eBErr}));
            checkOutput("aRdata", 64'(aRdata), 64'(mRdata[0]));
            checkOutput("bRdata", 64'(bRdata), 64'(mRdata[1]));
            checkOutput("memBus", 64'({memAddr, memWriteData, memSignMask}), 64'({mAddr, mWdata, mMask}));
            checkOutput("timeoutFlag", 64'(timeoutFlag), 64'(mTimeout));
        end
    end

    initial begin : stimulus
        int longRun;
        longRun = 0;
        reset = 1'b1;
        applyStimulus(0, 0, 12'h0, 0, 0, 12'h0, 32'h0, 4'h0, 0, 32'h0);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checkOutput("rst aRdata", 64'(aRdata), 64'(32'h0));
        checkOutput("rst timeout", 64'(timeoutFlag), 64'(1'b0));
        checkOutput("rst memAddr", 64'(memAddr), 64'(12'h0));

        // Read on A with two stall cycles in BUSY.
        applyStimulus(1, 0, 12'h010, 0, 0, 12'h0, 32'h0, 4'h0, 0, 32'h0);
        tick();
        checkOutput("rd issue", 64'({memMemread, memMemwrite}), 64'(2'b10));
        checkOutput("rd addr", 64'(memAddr), 64'(12'h010));
        memClkStall = 1'b1;
        tick();
        checkOutput("rd early done", 64'(aDone), 64'(1'b0));
        tick();
        tick();
        checkOutput("rd early done2", 64'(aDone), 64'(1'b0));
        memClkStall = 1'b0;
        memReadData = 32'hDEADBEEF;
        tick();
        checkOutput("rd done", 64'({aDone, aErr, bDone}), 64'(3'b100));
        checkOutput("rd data", 64'(aRdata), 64'(32'hDEADBEEF));
        aReq = 1'b0;
        memReadData = 32'h0;
        tick();

        // Write on B must not touch b_rdata.
        applyStimulus(0, 0, 12'h0, 1, 1, 12'h0A4, 32'h12345678, 4'b0100, 0, 32'hCAFEF00D);
        tick();
        checkOutput("wr strobe", 64'({memMemread, memMemwrite}), 64'(2'b01));
        checkOutput("wr data", 64'({memWriteData, memSignMask}), 64'({32'h12345678, 4'b0100}));
        tick();
        tick();
        checkOutput("wr done", 64'({bDone, bErr, aDone}), 64'(3'b100));
        checkOutput("wr rdata", 64'(bRdata), 64'(32'h0));
        bReq = 1'b0;
        tick();

        // Simultaneous requests: A then B.
        applyStimulus(1, 0, 12'h100, 1, 0, 12'h200, 32'h0, 4'h0, 0, 32'h11111111);
        tick();
        checkOutput("tie addr1", 64'(memAddr), 64'(12'h100));
        tick();
        tick();
        checkOutput("tie doneA", 64'({aDone, bDone}), 64'(2'b10));
        checkOutput("tie rdA", 64'(aRdata), 64'(32'h11111111));
        aReq = 1'b0;
        memReadData = 32'h22222222;
        tick();
        checkOutput("tie addr hold", 64'(memAddr), 64'(12'h100));
        tick();
        checkOutput("tie addr2", 64'(memAddr), 64'(12'h200));
        tick();
        tick();
        checkOutput("tie doneB", 64'({aDone, bDone}), 64'(2'b01));
        checkOutput("tie rdB", 64'(bRdata), 64'(32'h22222222));
        bReq = 1'b0;
        tick();

        // A pulses for one cycle while B is being served.
        applyStimulus(0, 0, 12'h0, 1, 0, 12'h300, 32'h0, 4'h0, 0, 32'h33333333);
        tick();
        aReq = 1'b1;
        aAddr = 12'h0FF;
        tick();
        aReq = 1'b0;
        tick();
        checkOutput("pulse doneB", 64'(bDone), 64'(1'b1));
        checkOutput("pulse rdB", 64'(bRdata), 64'(32'h33333333));
        bReq = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("pulse noA", 64'({aDone, memMemread}), 64'(2'b00));
        end

        // Timeout on A: stall never drops.
        applyStimulus(1, 0, 12'h7FC, 0, 0, 12'h0, 32'h0, 4'h0, 0, 32'h0);
        tick();
        memClkStall = 1'b1;
        for (int k = 2; k <= 17; k++) begin
            tick();
            if (k == 17) checkOutput("to early", 64'(aDone), 64'(1'b0));
        end
        tick();
        checkOutput("to doneErr", 64'({aDone, aErr, bDone, bErr}), 64'(4'b1100));
        checkOutput("to flag", 64'(timeoutFlag), 64'(1'b1));
        checkOutput("to rdata", 64'(aRdata), 64'(32'h11111111));
        aReq = 1'b0;
        repeat (3) tick();
        memClkStall = 1'b0;
        tick();
        checkOutput("to sticky", 64'(timeoutFlag), 64'(1'b1));

        // Reset in BUSY with stall held and a_req held.
        applyStimulus(1, 0, 12'h040, 0, 0, 12'h0, 32'h0, 4'h0, 0, 32'h0);
        tick();
        memClkStall = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst2 flag", 64'(timeoutFlag), 64'(1'b0));
        checkOutput("rst2 rdata", 64'(aRdata), 64'(32'h0));
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("rst2 quiet", 64'({aDone, memMemread}), 64'(2'b00));
        end
        memClkStall = 1'b0;
        memReadData = 32'h5A5A5A5A;
        tick();
        checkOutput("rst2 issue", 64'({memMemread, memAddr}), 64'({1'b1, 12'h040}));
        tick();
        tick();
        checkOutput("rst2 done", 64'({aDone, aErr}), 64'(2'b10));
        checkOutput("rst2 data", 64'(aRdata), 64'(32'h5A5A5A5A));
        aReq = 1'b0;
        tick();

        // Random traffic, requests held until the model says done.
        for (int i = 0; i < 3000; i++) begin
            tick();
            reset = ($urandom_range(0, 299) == 0);
            if (eADone) aReq = 1'b0;
            else if (aReq && $urandom_range(0, 19) == 0) aReq = 1'b0;
            else if (!aReq && $urandom_range(0, 3) == 0) begin
                aReq = 1'b1; aWe = 1'($urandom_range(0, 1)); aAddr = 12'($urandom);
                aWdata = $urandom; aMask = 4'($urandom);
            end
            if (eBDone) bReq = 1'b0;
            else if (bReq && $urandom_range(0, 19) == 0) bReq = 1'b0;
            else if (!bReq && $urandom_range(0, 3) == 0) begin
                bReq = 1'b1; bWe = 1'($urandom_range(0, 1)); bAddr = 12'($urandom);
                bWdata = $urandom; bMask = 4'($urandom);
            end
            if (longRun > 0) begin
                memClkStall = 1'b1;
                longRun--;
            end else if ($urandom_range(0, 39) == 0) begin
                longRun = $urandom_range(14, 22);
                memClkStall = 1'b1;
            end else begin
                memClkStall = ($urandom_range(0, 2) == 0);
            end
            memReadData = $urandom;
        end
        reset = 1'b0;
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
